// File: rtl/minibyte_mem_ctrl.sv
// MiniByte bus controller: one load/store at a time, decoded to ROM, RAM and I/O ports,
// with a registered response held until the CPU takes it.
module minibyte_mem_ctrl #(
   parameter logic [7:0] RAM_BASE = 8'h70,
   parameter int         RAM_AW   = 4,
   parameter logic [7:0] OUT_ADDR = 8'h40,
   parameter logic [7:0] IN_ADDR  = 8'h41
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_we,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic [5:0] rom_addr,
   input  logic [7:0] rom_data,
   input  logic [7:0] ext_in,
   output logic [7:0] out_port,
   output logic       out_strobe,
   output logic       err_unmapped
);

   localparam int RAM_DEPTH = 1 << RAM_AW;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

   state_e      state_q;
   logic [7:0]  addr_q, wdata_q;
   logic        we_q;
   logic        req_ready_q, rsp_valid_q, out_strobe_q, err_q;
   logic [7:0]  rsp_rdata_q, out_port_q;
   logic [7:0]  ram_q [RAM_DEPTH];

   logic              is_rom, is_out, is_in, is_ram;
   logic              ram_wr, out_wr, bad_d;
   logic [7:0]        rdata_d;
   logic [RAM_AW-1:0] ram_idx;

   assign ram_idx = addr_q[RAM_AW-1:0];
   assign is_rom  = (addr_q[7:6] == 2'b00);
   assign is_out  = (addr_q == OUT_ADDR);
   assign is_in   = (addr_q == IN_ADDR);
   assign is_ram  = (addr_q[7:RAM_AW] == RAM_BASE[7:RAM_AW]);
   assign ram_wr  = we_q && is_ram && !is_out && !is_in;
   assign out_wr  = we_q && is_out;

   // Port addresses take priority so a parameter overlap never aliases a port into RAM.
   always_comb begin
      rdata_d = 8'h00;
      bad_d   = 1'b0;
      if (we_q)        bad_d   = !(is_out || (is_ram && !is_in));
      else if (is_out) rdata_d = out_port_q;
      else if (is_in)  rdata_d = ext_in;
      else if (is_rom) rdata_d = rom_data;
      else if (is_ram) rdata_d = ram_q[ram_idx];
      else             bad_d   = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= 8'h00;
         wdata_q      <= 8'h00;
         we_q         <= 1'b0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= 8'h00;
         out_port_q   <= 8'h00;
         out_strobe_q <= 1'b0;
         err_q        <= 1'b0;
         for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= 8'h00;
      end else begin
         out_strobe_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid && req_ready_q) begin
                  addr_q      <= req_addr;
                  we_q        <= req_we;
                  wdata_q     <= req_wdata;
                  req_ready_q <= 1'b0;
                  state_q     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               rsp_rdata_q <= rdata_d;
               rsp_valid_q <= 1'b1;
               if (bad_d)  err_q <= 1'b1;
               if (ram_wr) ram_q[ram_idx] <= wdata_q;
               if (out_wr) begin
                  out_port_q   <= wdata_q;
                  out_strobe_q <= 1'b1;
               end
               state_q <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready    = req_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rom_addr     = addr_q[5:0];
   assign out_port     = out_port_q;
   assign out_strobe   = out_strobe_q;
   assign err_unmapped = err_q;

endmodule
